nvdla_cfg_apb_master: RTL and testbench
=======================================

// Module: nvdla_cfg_apb_master
// PURPOSE
//  - Upstream neighbour of the NVDLA config port: converts CPU-side MMIO requests (valid/ready)
//    into APB3 master transfers driving the NVDLA s_apb (psel/penable/pwrite/paddr/pwdata).
//  - Decodes a base-address window, rebases addresses to NVDLA offsets and returns read data/error.
//  - Exactly one transaction is outstanding at a time.
// PARAMETERS
//  BASE_ADDR       32'h4000_0000  CPU address mapped to NVDLA offset 0
//  WINDOW_SIZE     32'h0004_0000  window size in bytes (power of two); NVDLA csb covers 256 KB
//  TIMEOUT_CYCLES  1024           ACCESS-phase cycle limit (used only with NVDLA_APB_TIMEOUT_EN)
// PORTS
//  csb_clk     in   1   APB/CSB clock; the only clock
//  csb_rst     in   1   synchronous active-high reset
//  req_valid   in   1   CPU request valid
//  req_ready   out  1   request accepted when req_valid && req_ready
//  req_write   in   1   1 = write, 0 = read
//  req_addr    in   32  CPU byte address
//  req_wdata   in   32  write data
//  rsp_valid   out  1   response valid; held until rsp_ready
//  rsp_ready   in   1   CPU response ready
//  rsp_rdata   out  32  read data (0 for writes/errors)
//  rsp_err     out  1   decode, alignment, pslverr or timeout error
//  psel        out  1   APB select
//  penable     out  1   APB enable
//  pwrite      out  1   APB direction
//  paddr       out  32  APB address = req_addr - BASE_ADDR
//  pwdata      out  32  APB write data
//  prdata      in   32  APB read data
//  pready      in   1   APB ready
//  pslverr     in   1   APB slave error
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, psel=0, penable=0,
//    pwrite=0, paddr=0, pwdata=0. csb_rst mid-transfer aborts: psel/penable drop on the next edge, no response.
//  - All outputs are registered. FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE; IDLE -> RESP on error.
//  - IDLE: req_ready=1. On accept, latch write/addr/wdata and set req_ready=0.
//      addr outside [BASE_ADDR, BASE_ADDR+WINDOW_SIZE) or addr[1:0]!=0 -> RESP, rsp_err=1,
//      rsp_rdata=0, no APB activity. Otherwise -> SETUP.
//  - SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata valid, then -> ACCESS.
//  - ACCESS: psel=1, penable=1, paddr/pwrite/pwdata held stable. When pready=1: capture
//    rsp_rdata=(read ? prdata : 0), rsp_err=pslverr, drop psel/penable, then -> RESP.
//  - RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1, then -> IDLE.
//    When rsp_ready=1 in the first RESP cycle: rsp_valid=0 and req_ready=1 on the next edge.
//  - Latency with zero APB wait states: accepted at edge T -> SETUP T+1, ACCESS T+2 with pready=1
//    -> rsp_valid asserted from T+3. Each pready-low cycle adds one cycle. Error response at T+1.
//  - req_valid in any non-IDLE state is ignored (req_ready=0). prdata/pslverr are ignored while pready=0.
//  - Window compare: 32-bit unsigned subtract. BASE_ADDR+WINDOW_SIZE must not wrap past 2^32
//    (elaboration-time assertion).
// CONFIGURATION
//  NVDLA_APB_TIMEOUT_EN defined: a 16-bit counter clears on SETUP entry and increments each
//    ACCESS cycle with pready=0. At TIMEOUT_CYCLES, drop psel/penable, rsp_err=1, rsp_rdata=0
//    -> RESP. A pready arriving after the timeout is ignored.
//  NVDLA_APB_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely for pready.
// TESTING
//  1 Write BASE+0x1004, data 0xA5A5_0001, pready=1 immediately -> paddr=0x1004, pwrite=1,
//    SETUP then ACCESS one cycle each, rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
//  2 Read BASE+0x0000, pready low 3 cycles, prdata=0x0010_0001 -> ACCESS lasts 4 cycles,
//    rsp_rdata=0x0010_0001, rsp_valid at T+6.
//  3 Read 0x3FFF_FFFC (below window), then misaligned BASE+0x2 -> each rsp_err=1 at T+1,
//    psel never asserted.
//  4 Write with pslverr=1 on the pready cycle -> rsp_err=1. Hold rsp_ready=0 for 5 cycles ->
//    response stable and req_ready=0 for the whole hold.
//  5 Assert csb_rst in ACCESS -> next edge psel=penable=0, rsp_valid=0, req_ready=1. A new read
//    then completes normally.
//  6 (NVDLA_APB_TIMEOUT_EN, TIMEOUT_CYCLES=8) pready held 0 -> after 8 ACCESS cycles psel
//    drops and rsp_err=1. Without the macro, the bench stays in ACCESS for 100 cycles.

Source files
------------

// File: rtl/nvdla_cfg_apb_master_if.sv
// CPU-side MMIO request/response channel and APB3 bus used by nvdla_cfg_apb_master.
// Each interface has a master modport (initiator) and a slave modport (target).

interface nvdla_mmio_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface nvdla_apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/nvdla_cfg_apb_master.sv
// MMIO valid/ready to APB3 master bridge for the NVDLA config port, one transfer in flight.
// Optional ACCESS-phase timeout enabled by defining NVDLA_APB_TIMEOUT_EN.

module nvdla_cfg_apb_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
    parameter logic [31:0] WINDOW_SIZE    = 32'h0004_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic         csb_clk,
    input logic         csb_rst,
    nvdla_mmio_if.slave cpu,
    nvdla_apb_if.master apb
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam logic [32:0] WINDOW_END = {1'b0, BASE_ADDR} + {1'b0, WINDOW_SIZE};

    generate
        if (WINDOW_END > 33'h1_0000_0000) begin : g_window_wrap
            $error("BASE_ADDR + WINDOW_SIZE wraps past 2^32");
        end
        if (WINDOW_SIZE == 32'd0 || (WINDOW_SIZE & (WINDOW_SIZE - 32'd1)) != 32'd0) begin : g_window_pow2
            $error("WINDOW_SIZE must be a non-zero power of two");
        end
        if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
            $error("TIMEOUT_CYCLES must fit the 16-bit timeout counter");
        end
    endgenerate

    state_e      state_q;
    logic        req_ready_q;
    logic        dec_err_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;

`ifdef NVDLA_APB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;
`endif

    // An address below BASE_ADDR wraps to a huge offset, so one compare covers both window edges.
    logic [31:0] paddr_d;
    logic        dec_err_d;
    assign paddr_d   = cpu.req_addr - BASE_ADDR;
    assign dec_err_d = (paddr_d >= WINDOW_SIZE) || (cpu.req_addr[1:0] != 2'b00);

    // NOTE: every register uses non-blocking (<=) so all updates in this block see pre-edge values.
    always_ff @(posedge csb_clk) begin
        if (csb_rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            dec_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
`ifdef NVDLA_APB_TIMEOUT_EN
            tmo_cnt_q   <= 16'h0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_ready_q) begin
                        if (cpu.req_valid) begin
                            req_ready_q <= 1'b0;
                            pwrite_q    <= cpu.req_write;
                            paddr_q     <= paddr_d;
                            pwdata_q    <= cpu.req_wdata;
                            dec_err_q   <= dec_err_d;
                        end
                    end else if (dec_err_q) begin
                        // Decode/alignment failure: answer without touching the APB bus.
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                    end else begin
                        state_q   <= ST_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
`ifdef NVDLA_APB_TIMEOUT_EN
                        tmo_cnt_q <= 16'h0;
`endif
                    end
                end

                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end

                ST_ACCESS: begin
                    if (apb.pready) begin
                        state_q     <= ST_RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? 32'h0 : apb.prdata;
                        rsp_err_q   <= apb.pslverr;
                    end
`ifdef NVDLA_APB_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_q     <= ST_RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end

                ST_RESP: begin
                    if (cpu.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu.req_ready = req_ready_q;
    assign cpu.rsp_valid = rsp_valid_q;
    assign cpu.rsp_rdata = rsp_rdata_q;
    assign cpu.rsp_err   = rsp_err_q;

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_nvdla_cfg_apb_master.sv
// Self-checking bench for nvdla_cfg_apb_master: vector table plus reset-abort and timeout/hang sequences.
// Timeout expectations follow NVDLA_APB_TIMEOUT_EN with TIMEOUT_CYCLES=8.

module tb_nvdla_cfg_apb_master;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        int          hold;
        logic        exp_apb;
        logic [31:0] exp_paddr;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic csb_clk = 1'b0;
    logic csb_rst = 1'b1;

    nvdla_mmio_if mmio ();
    nvdla_apb_if  apb ();

    nvdla_cfg_apb_master #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .csb_clk(csb_clk),
        .csb_rst(csb_rst),
        .cpu    (mmio),
        .apb    (apb)
    );

    always #5 csb_clk = ~csb_clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t sb_q[$];

    int          slv_wait  = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // APB slave model: drives junk on prdata/pslverr during wait states, real data on the pready cycle.
    initial begin
        int acc_cnt;
        acc_cnt     = 0;
        apb.pready  = 1'b0;
        apb.prdata  = 32'h0;
        apb.pslverr = 1'b0;
        forever begin
            @(negedge csb_clk);
            if (apb.psel && apb.penable) begin
                if (acc_cnt >= slv_wait) begin
                    apb.pready  = 1'b1;
                    apb.prdata  = slv_rdata;
                    apb.pslverr = slv_err;
                end else begin
                    apb.pready  = 1'b0;
                    apb.prdata  = 32'hDEAD_BEEF;
                    apb.pslverr = 1'b1;
                end
                acc_cnt++;
            end else begin
                acc_cnt     = 0;
                apb.pready  = 1'b0;
                apb.prdata  = 32'h0;
                apb.pslverr = 1'b0;
            end
        end
    end

    // Returns at the negedge following the accepting edge.
    task automatic send_req(input logic write, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        while (!mmio.req_ready && n < 50) begin
            @(negedge csb_clk);
            n++;
        end
        check("req_ready_idle", mmio.req_ready, 1);
        mmio.req_valid = 1'b1;
        mmio.req_write = write;
        mmio.req_addr  = addr;
        mmio.req_wdata = wdata;
        @(posedge csb_clk);
        @(negedge csb_clk);
        mmio.req_valid = 1'b0;
        mmio.req_addr  = 32'hFFFF_FFFF;
        mmio.req_wdata = 32'h0;
        check("req_ready_busy", mmio.req_ready, 0);
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int   lat;
        logic saw_psel;
        logic apb_ok;
        logic hold_ok;
        rsp_t got;
        slv_wait  = v.waits;
        slv_rdata = v.prdata;
        slv_err   = v.slverr;
        send_req(v.write, v.addr, v.wdata);
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        lat      = 0;
        saw_psel = 1'b0;
        apb_ok   = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge csb_clk);
            if (apb.psel) begin
                saw_psel = 1'b1;
                apb_ok &= (apb.penable == (c != 1));
                apb_ok &= (apb.paddr == v.exp_paddr) && (apb.pwrite == v.write);
                apb_ok &= (!v.write || apb.pwdata == v.wdata);
            end
            if (mmio.rsp_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_apb_seen"}, saw_psel, v.exp_apb);
        check({tag, "_psel_dropped"}, {apb.psel, apb.penable}, 2'b00);
        if (v.exp_apb) check({tag, "_apb_phases"}, apb_ok, 1);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
            got = '{rdata: 32'h0, err: 1'b0};
        end else begin
            got = sb_q.pop_front();
        end
        check({tag, "_rdata"}, mmio.rsp_rdata, got.rdata);
        check({tag, "_err"}, mmio.rsp_err, got.err);
        hold_ok = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge csb_clk);
            hold_ok &= mmio.rsp_valid && !mmio.req_ready;
            hold_ok &= (mmio.rsp_rdata == got.rdata) && (mmio.rsp_err == got.err);
        end
        if (v.hold > 0) check({tag, "_hold_stable"}, hold_ok, 1);
        mmio.rsp_ready = 1'b1;
        @(negedge csb_clk);
        mmio.rsp_ready = 1'b0;
        check({tag, "_rsp_valid_clear"}, mmio.rsp_valid, 0);
        check({tag, "_req_ready_back"}, mmio.req_ready, 1);
    endtask

    initial begin
        vec_t vecs[9];
        logic ok;
        int   n;

        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        logic ok;
        int   n;
        vec_t tmo_v;

        //          wr    addr           wdata          wt  prdata         serr hold apb paddr         lat rdata          err
        vecs[0] = '{1'b1, 32'h4000_1004, 32'hA5A5_0001, 0, 32'h1111_2222, 1'b0, 0, 1'b1, 32'h0000_1004, 3, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h4000_0000, 32'h0,         3, 32'h0010_0001, 1'b0, 0, 1'b1, 32'h0000_0000, 6, 32'h0010_0001, 1'b0};
        vecs[2] = '{1'b0, 32'h3FFF_FFFC, 32'h0,         0, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h4000_0002, 32'h0,         0, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 32'h4000_0008, 32'h1234_ABCD, 0, 32'h0,         1'b1, 5, 1'b1, 32'h0000_0008, 3, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 32'h4003_FFFC, 32'h0,         1, 32'h89AB_CDEF, 1'b0, 2, 1'b1, 32'h0003_FFFC, 4, 32'h89AB_CDEF, 1'b0};
        vecs[6] = '{1'b0, 32'h4004_0000, 32'h0,         0, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1, 32'h0,         1'b1};
        vecs[7] = '{1'b1, 32'h4000_0010, 32'h0F0F_F0F0, 2, 32'h5555_AAAA, 1'b0, 0, 1'b1, 32'h0000_0010, 5, 32'h0,         1'b0};
        vecs[8] = '{1'b0, 32'h4000_0020, 32'h0,         0, 32'hFFFF_0000, 1'b0, 1, 1'b1, 32'h0000_0020, 3, 32'hFFFF_0000, 1'b0};

        // NOTE: bench drives stimulus with blocking assignments, away from the sampling edge.
        mmio.req_valid = 1'b0;
        mmio.req_write = 1'b0;
        mmio.req_addr  = 32'h0;
        mmio.req_wdata = 32'h0;
        mmio.rsp_ready = 1'b0;
        csb_rst        = 1'b1;
        repeat (2) @(posedge csb_clk);
        @(negedge csb_clk);
        check("rst_req_ready", mmio.req_ready, 1);
        check("rst_rsp_valid", mmio.rsp_valid, 0);
        check("rst_rsp_rdata", mmio.rsp_rdata, 32'h0);
        check("rst_rsp_err", mmio.rsp_err, 0);
        check("rst_psel_penable", {apb.psel, apb.penable, apb.pwrite}, 3'b000);
        check("rst_paddr", apb.paddr, 32'h0);
        check("rst_pwdata", apb.pwdata, 32'h0);
        csb_rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while in ACCESS: the transfer is dropped and no response is produced.
        slv_wait = 1000;
        send_req(1'b0, 32'h4000_0100, 32'h0);
        n = 0;
        while (!apb.penable && n < 10) begin
            @(negedge csb_clk);
            n++;
        end
        check("abort_reached_access", apb.penable, 1);
        csb_rst = 1'b1;
        @(negedge csb_clk);
        csb_rst = 1'b0;
        check("abort_psel_penable", {apb.psel, apb.penable}, 2'b00);
        check("abort_rsp_valid", mmio.rsp_valid, 0);
        check("abort_req_ready", mmio.req_ready, 1);
        ok = 1'b1;
        repeat (4) begin
            @(negedge csb_clk);
            ok &= !mmio.rsp_valid && !apb.psel;
        end
        check("abort_quiet", ok, 1);
        run_txn("post_abort_read",
                '{1'b0, 32'h4000_0044, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 0, 1'b1, 32'h0000_0044, 3, 32'h0BAD_F00D, 1'b0});

`ifdef NVDLA_APB_TIMEOUT_EN
        tmo_v = '{1'b0, 32'h4000_0200, 32'h0, 1000, 32'h7777_7777, 1'b0, 0, 1'b1, 32'h0000_0200, 10, 32'h0, 1'b1};
        run_txn("timeout", tmo_v);
`else
        slv_wait = 1000;
        send_req(1'b0, 32'h4000_0200, 32'h0);
        ok = 1'b1;
        for (int c = 1; c <= 102; c++) begin
            @(negedge csb_clk);
            if (c >= 2) ok &= apb.psel && apb.penable && !mmio.rsp_valid;
        end
        check("hang_stays_in_access", ok, 1);
        csb_rst = 1'b1;
        @(negedge csb_clk);
        csb_rst = 1'b0;
        check("hang_reset_recovers", {mmio.req_ready, apb.psel}, 2'b10);
        tmo_v = '{1'b1, 32'h4000_0300, 32'hC0DE_0001, 0, 32'h0, 1'b0, 0, 1'b1, 32'h0000_0300, 3, 32'h0, 1'b0};
        run_txn("post_hang_write", tmo_v);
`endif

        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
